// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// The segment encoding is {a,b,c,d,e,f,g}, active-low, for common-anode digits.
package sev_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Hex glyphs 0-9, A, b, C, d, E, F.
  localparam seg_t HEX_GLYPHS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  function automatic seg_t hex_glyph(input logic [3:0] nib);
    return HEX_GLYPHS[nib];
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot counter for the scan controller. Counts 0..TICK_DIV-1 per digit slot
// and flags the last blanking cycle and the last cycle of the slot.
module scan_tick_gen #(
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_blank_done,
  output logic o_slot_done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Free-running slot counter, wraps at the end of every slot so it never overflows.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == SLOT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_blank_done = (r_cnt == BLANK_LAST);
  assign o_slot_done  = (r_cnt == SLOT_LAST);

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered
// display value. Optional leading-zero blanking is enabled by defining
// SEV_SEG_LZB_EN.
module sev_seg_scan_ctrl
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    ready,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_t r_state, w_nxt_state;
  logic [IW-1:0] r_idx, w_nxt_idx;
  logic w_blank_done, w_slot_done, w_frame_end;

  logic [4*NUM_DIGITS-1:0] r_pend_val, r_act_val, w_act_val_nxt;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp, w_act_dp_nxt;
  logic                    r_pend_vld, w_pend_vld_nxt;
  logic                    w_xfer, w_commit;

  logic [3:0]            w_nib_sel;
  seg_t                  w_seg_nxt;
  logic                  w_dp_n_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  seg_t                  r_seg;
  logic                  r_dp_n, r_ready;
  logic [NUM_DIGITS-1:0] r_an;

  scan_tick_gen #(
    .TICK_DIV    (TICK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_tick (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_blank_done(w_blank_done),
    .o_slot_done (w_slot_done)
  );

  // FSM state and digit index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BLANK;
      r_idx   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
    end
  end

  // Next-state logic: blank guard, then drive, then advance to the next digit.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_frame_end = 1'b0;
    case (r_state)
      BLANK: begin
        if (w_blank_done) w_nxt_state = DRIVE;
      end
      DRIVE: begin
        if (w_slot_done) begin
          w_nxt_state = BLANK;
          w_frame_end = (r_idx == LAST_IDX);
          w_nxt_idx   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
      end
      default: w_nxt_state = BLANK;
    endcase
  end

  // A transfer needs pend_vld clear and a commit needs it set, so they never
  // coincide; a value captured in the boundary cycle waits a whole frame.
  assign w_xfer         = load && !r_pend_vld;
  assign w_commit       = w_frame_end && r_pend_vld;
  assign w_act_val_nxt  = w_commit ? r_pend_val : r_act_val;
  assign w_act_dp_nxt   = w_commit ? r_pend_dp  : r_act_dp;
  assign w_pend_vld_nxt = w_commit ? 1'b0 : (w_xfer ? 1'b1 : r_pend_vld);

  // Pending/active double buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
      r_act_val  <= '0;
      r_act_dp   <= '0;
    end else begin
      if (w_xfer) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_mask;
      end
      r_pend_vld <= w_pend_vld_nxt;
      r_act_val  <= w_act_val_nxt;
      r_act_dp   <= w_act_dp_nxt;
    end
  end

  // Pin values for the next cycle, derived from next state so the registered
  // pins line up with the FSM state rather than trailing it by a cycle.
  always_comb begin
    w_nib_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_nxt_idx == IW'(i)) w_nib_sel = w_act_val_nxt[4*i +: 4];
    end
    w_seg_nxt = hex_glyph(w_nib_sel);
`ifdef SEV_SEG_LZB_EN
    // A digit is a leading zero when it and every higher nibble are zero.
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if ((w_nxt_idx == IW'(i)) && ((w_act_val_nxt >> (4*i)) == '0)) w_seg_nxt = SEG_BLANK;
    end
`endif
    w_an_nxt   = '1;
    w_dp_n_nxt = 1'b1;
    if (w_nxt_state == DRIVE) begin
      w_an_nxt   = ~(NUM_DIGITS'(1) << w_nxt_idx);
      w_dp_n_nxt = ~w_act_dp_nxt[w_nxt_idx];
    end else begin
      w_seg_nxt  = SEG_BLANK;
    end
  end

  // Output registers: no combinational path from inputs to pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an    <= '1;
      r_seg   <= SEG_BLANK;
      r_dp_n  <= 1'b1;
      r_ready <= 1'b1;
    end else begin
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_dp_n  <= w_dp_n_nxt;
      r_ready <= ~w_pend_vld_nxt;
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign dp_n  = r_dp_n;
  assign ready = r_ready;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Bench for sev_seg_scan_ctrl with NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
// Honours SEV_SEG_LZB_EN in the same way as the design.
module tb_sev_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int TD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * TD;
  localparam int NSPOT = 16;
  localparam int NLOAD = 4;
`ifdef SEV_SEG_LZB_EN
  localparam logic [6:0] HI_SEG = 7'h7F;
`else
  localparam logic [6:0] HI_SEG = 7'b0000001;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic        ready;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;

  typedef struct {
    int         ph;
    int         t;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       ready;
  } exp_t;

  typedef struct {
    int          ph;
    int          t;
    logic [15:0] v;
    logic [3:0]  dp;
  } load_t;

  exp_t  sb_q[$];
  exp_t  spots[NSPOT];
  load_t loads[NLOAD];
  int    checks = 0;
  int    errors = 0;
  int    spot_hits = 0;

  sev_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .TICK_DIV    (TD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .value  (value),
    .dp_mask(dp_mask),
    .ready  (ready),
    .seg    (seg),
    .dp_n   (dp_n),
    .an     (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Expected pins for cycle t after reset release, given the displayed value.
  function automatic exp_t model_out(input int ph, input int t, input logic [15:0] a,
                                     input logic [3:0] d, input logic pv);
    exp_t e;
    int pos, dig;
    logic [15:0] sh;
    pos = t % TD;
    dig = (t / TD) % ND;
    e.ph = ph;
    e.t = t;
    e.ready = !pv;
    if (pos < BC) begin
      e.an = 4'hF;
      e.seg = 7'h7F;
      e.dp_n = 1'b1;
    end else begin
      sh = a >> (4 * dig);
      e.an = ~(4'b0001 << dig);
      e.seg = glyph(sh[3:0]);
`ifdef SEV_SEG_LZB_EN
      if (dig != 0 && sh == 16'h0000) e.seg = 7'h7F;
`endif
      e.dp_n = !d[dig];
    end
    return e;
  endfunction

  function automatic exp_t mk(input int ph, input int t, input logic [3:0] a,
                              input logic [6:0] s, input logic dn, input logic r);
    exp_t e;
    e.ph = ph; e.t = t; e.an = a; e.seg = s; e.dp_n = dn; e.ready = r;
    return e;
  endfunction

  // Scoreboard consumer: every cycle's expectation is popped at the falling edge.
  always @(negedge clk) begin : sampler
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg || dp_n !== e.dp_n || ready !== e.ready) begin
        errors++;
        $display("FAIL scan ph%0d t=%0d got an=%b seg=%b dp_n=%b ready=%b want an=%b seg=%b dp_n=%b ready=%b",
                 e.ph, e.t, an, seg, dp_n, ready, e.an, e.seg, e.dp_n, e.ready);
      end
      for (int i = 0; i < NSPOT; i++) begin
        if (spots[i].ph == e.ph && spots[i].t == e.t) begin
          spot_hits++;
          checks++;
          if (an !== spots[i].an || seg !== spots[i].seg || dp_n !== spots[i].dp_n ||
              ready !== spots[i].ready) begin
            errors++;
            $display("FAIL spot ph%0d t=%0d got an=%b seg=%b dp_n=%b ready=%b want an=%b seg=%b dp_n=%b ready=%b",
                     e.ph, e.t, an, seg, dp_n, ready, spots[i].an, spots[i].seg,
                     spots[i].dp_n, spots[i].ready);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives n cycles starting at cycle 0 (called just after reset release).
  task automatic run_phase(input int ph, input int n);
    logic [15:0] a, pa;
    logic [3:0]  d, pd;
    logic        pv, hit;
    a = '0; pa = '0; d = '0; pd = '0; pv = 1'b0;
    for (int t = 0; t < n; t++) begin
      sb_q.push_back(model_out(ph, t, a, d, pv));
      hit = 1'b0;
      for (int k = 0; k < NLOAD; k++) begin
        if (loads[k].ph == ph && loads[k].t == t) begin
          hit = 1'b1;
          value = loads[k].v;
          dp_mask = loads[k].dp;
        end
      end
      load = hit;
      if (!hit) begin
        value = 16'($urandom);
        dp_mask = 4'($urandom);
      end
      if ((t % FRAME) == FRAME - 1 && pv) begin
        a = pa; d = pd; pv = 1'b0;
      end else if (load && !pv) begin
        pa = value; pd = dp_mask; pv = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    load = 1'b0;
  endtask

  task automatic check_reset_pins(input string name);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s got an=%b seg=%b dp_n=%b ready=%b want an=1111 seg=1111111 dp_n=1 ready=1",
               name, an, seg, dp_n, ready);
    end
  endtask

  initial begin
    loads[0] = '{1, 5,   16'h12AF, 4'b0100};  // accepted
    loads[1] = '{1, 10,  16'h3333, 4'b1111};  // ready low: ignored
    loads[2] = '{1, 63,  16'h0050, 4'b0000};  // in the boundary cycle
    loads[3] = '{1, 140, 16'hBEEF, 4'b1111};  // left pending, then reset

    spots[0]  = mk(1, 0,   4'hF, 7'h7F,      1'b1, 1'b1);
    spots[1]  = mk(1, 2,   4'hE, 7'b0000001, 1'b1, 1'b1);
    spots[2]  = mk(1, 6,   4'hE, 7'b0000001, 1'b1, 1'b0);
    spots[3]  = mk(1, 10,  4'hD, 7'b0000001, 1'b1, 1'b0);
    spots[4]  = mk(1, 34,  4'hE, 7'b0111000, 1'b1, 1'b1);
    spots[5]  = mk(1, 42,  4'hD, 7'b0001000, 1'b1, 1'b1);
    spots[6]  = mk(1, 50,  4'hB, 7'b0010010, 1'b0, 1'b1);
    spots[7]  = mk(1, 58,  4'h7, 7'b1001111, 1'b1, 1'b1);
    spots[8]  = mk(1, 64,  4'hF, 7'h7F,      1'b1, 1'b0);
    spots[9]  = mk(1, 66,  4'hE, 7'b0111000, 1'b1, 1'b0);
    spots[10] = mk(1, 96,  4'hF, 7'h7F,      1'b1, 1'b1);
    spots[11] = mk(1, 98,  4'hE, 7'b0000001, 1'b1, 1'b1);
    spots[12] = mk(1, 106, 4'hD, 7'b0100100, 1'b1, 1'b1);
    spots[13] = mk(1, 114, 4'hB, HI_SEG,     1'b1, 1'b1);
    spots[14] = mk(1, 122, 4'h7, HI_SEG,     1'b1, 1'b1);
    spots[15] = mk(3, 34,  4'hE, 7'b0000001, 1'b1, 1'b1);

    do_reset();
    check_reset_pins("reset_release");
    run_phase(1, 148);

    // Cycle 148 is mid digit-2 drive; reset must clear the pins immediately.
    #1 rst = 1'b1;
    #1 check_reset_pins("async_reset");
    repeat (2) @(posedge clk);
    #1 check_reset_pins("reset_held");
    rst = 1'b0;
    run_phase(3, 46);

    checks++;
    if (spot_hits != NSPOT) begin
      errors++;
      $display("FAIL spot_coverage got %0d want %0d", spot_hits, NSPOT);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
